// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and state encoding for the seg_scan_ctrl display scanner.
package seg_scan_ctrl_pkg;

    localparam int unsigned SEG_NUM_DIGITS = 3;
    localparam int unsigned SEG_NIB_W      = 4;

    typedef enum logic {
        StBlank = 1'b0,
        StShow  = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot phase counter: counts 0..phase_len-1 while run is high and clears when the phase ends.
module seg_scan_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] phase_len,
    output logic             phase_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign phase_done = (cnt_q == phase_len - CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = phase_done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan scheduler with blank gaps and frame-boundary updates.
// Optional feature: define SEG_BLANK_LZ_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = SEG_NUM_DIGITS,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            run,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [SEG_NIB_W*NUM_DIGITS-1:0] wr_digits,
    input  logic [NUM_DIGITS-1:0]           wr_dp,
    output logic [SEG_NIB_W-1:0]            display_out,
    output logic                            dp_out,
    output logic [NUM_DIGITS-1:0]           en_out,
    output logic                            frame_start
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    seg_state_e                           state_q, state_d;
    logic [IdxW-1:0]                      idx_q, idx_d;
    logic [NUM_DIGITS-1:0][SEG_NIB_W-1:0] act_dig_q, act_dig_d, shd_dig_q, shd_dig_d;
    logic [NUM_DIGITS-1:0]                act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic                                 pending_q, pending_d;
    logic [SEG_NIB_W-1:0]                 display_q, display_d;
    logic                                 dp_q, dp_d;
    logic [NUM_DIGITS-1:0]                en_q, en_d;
    logic                                 frame_start_q, frame_start_d;

    logic [CntW-1:0]       phase_len;
    logic                  phase_done, step, wrap, accept;
    logic [NUM_DIGITS-1:0] suppress;

    assign phase_len = (state_q == StBlank) ? CntW'(BLANK_CYCLES)
                                            : CntW'(SCAN_DIV - BLANK_CYCLES);

    seg_scan_timer #(
        .CNT_W(CntW)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .phase_len (phase_len),
        .phase_done(phase_done)
    );

    assign step   = run && phase_done;
    assign wrap   = step && (state_q == StShow) && (idx_q == LastIdx);
    assign accept = wr_valid && !pending_q;

`ifdef SEG_BLANK_LZ_EN
    logic lead_zero;

    // Walk from the most significant digit; a nonzero nibble or a set dp ends suppression.
    always_comb begin
        suppress  = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero   = lead_zero && (act_dig_q[i] == '0) && !act_dp_q[i];
            suppress[i] = lead_zero;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        act_dig_d     = act_dig_q;
        act_dp_d      = act_dp_q;
        shd_dig_d     = shd_dig_q;
        shd_dp_d      = shd_dp_q;
        pending_d     = pending_q;

        if (step) begin
            if (state_q == StBlank) begin
                state_d = StShow;
            end else begin
                state_d = StBlank;
                idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
            end
        end

        // Accept needs pending clear and commit needs it set, so they never collide.
        if (accept) begin
            shd_dig_d = wr_digits;
            shd_dp_d  = wr_dp;
            pending_d = 1'b1;
        end else if (wrap && pending_q) begin
            act_dig_d = shd_dig_q;
            act_dp_d  = shd_dp_q;
            pending_d = 1'b0;
        end

        display_d     = act_dig_q[idx_q];
        dp_d          = act_dp_q[idx_q];
        en_d          = ((state_q == StShow) && !suppress[idx_q])
                        ? (NUM_DIGITS'(1) << idx_q) : '0;
        frame_start_d = wrap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StBlank;
            idx_q         <= '0;
            act_dig_q     <= '0;
            act_dp_q      <= '0;
            shd_dig_q     <= '0;
            shd_dp_q      <= '0;
            pending_q     <= 1'b0;
            display_q     <= '0;
            dp_q          <= 1'b0;
            en_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            act_dig_q     <= act_dig_d;
            act_dp_q      <= act_dp_d;
            shd_dig_q     <= shd_dig_d;
            shd_dp_q      <= shd_dp_d;
            pending_q     <= pending_d;
            display_q     <= display_d;
            dp_q          <= dp_d;
            en_q          <= en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wr_ready    = !pending_q;
    assign display_out = display_q;
    assign dp_out      = dp_q;
    assign en_out      = run ? en_q : '0;
    assign frame_start = frame_start_q;

endmodule
